// File: rtl/joypad_port.sv
// NES standard-controller pair behind $4016/$4017: synchronised, debounced buttons
// parallel-loaded on STROBE and shifted out one bit per CPU read edge.
module joypad_port #(
  parameter int   DB_W      = 16,
  parameter int   DB_CYCLES = 50000,
  parameter logic FILL_BIT  = 1'b1
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic [7:0] BTN1,
  input  logic [7:0] BTN2,
  input  logic       STROBE,
  input  logic       RD1,
  input  logic       RD2,
  output logic       DOUT1,
  output logic       DOUT2,
  output logic [7:0] PRESSED1,
  output logic [7:0] PRESSED2
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Both ports share one 16-bit debounce datapath: [7:0] port 1, [15:8] port 2.
  logic [15:0]     btn_raw;
  logic [15:0]     sync1_q, sync2_q;
  logic [15:0]     pressed_q, pressed_d;
  logic [DB_W-1:0] cnt_q [16];
  logic [DB_W-1:0] cnt_d [16];
  logic [7:0]      sr1_q, sr1_d;
  logic [7:0]      sr2_q, sr2_d;
  logic            rd1_q, rd2_q;
  logic            rd_edge1, rd_edge2;

  function automatic logic [7:0] shift_in(input logic [7:0] sr);
    return {FILL_BIT, sr[7:1]};
  endfunction

  assign btn_raw  = {BTN2, BTN1};
  assign rd_edge1 = RD1 & ~rd1_q;
  assign rd_edge2 = RD2 & ~rd2_q;

  // Debounce: a bit flips only after DB_CYCLES consecutive mismatching cycles.
  always_comb begin
    pressed_d = pressed_q;
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != pressed_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          pressed_d[i] = ~pressed_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Shift registers: load wins over a simultaneous read edge.
  always_comb begin
    sr1_d = sr1_q;
    sr2_d = sr2_q;
    if (STROBE) begin
      sr1_d = pressed_q[7:0];
      sr2_d = pressed_q[15:8];
    end else begin
      if (rd_edge1) sr1_d = shift_in(sr1_q);
      if (rd_edge2) sr2_d = shift_in(sr2_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RES) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pressed_q <= '0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      rd1_q     <= 1'b0;
      rd2_q     <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
      sr1_q     <= sr1_d;
      sr2_q     <= sr2_d;
      rd1_q     <= RD1;
      rd2_q     <= RD2;
    end
  end

  assign DOUT1    = sr1_q[0];
  assign DOUT2    = sr2_q[0];
  assign PRESSED1 = pressed_q[7:0];
  assign PRESSED2 = pressed_q[15:8];

endmodule

// File: tb/tb_joypad_port.sv
// Bench for joypad_port with a short debounce window; serial bits are scored
// against a small shift-register model through an expected-value queue.
module tb_joypad_port;

  logic       CLK = 1'b0;
  logic       RES;
  logic [7:0] BTN1, BTN2;
  logic       STROBE, RD1, RD2;
  logic       DOUT1, DOUT2;
  logic [7:0] PRESSED1, PRESSED2;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] exp_p1, exp_p2;   // button values the bench expects to be debounced
  logic [7:0] sr1_m, sr2_m;     // model of the two shift registers
  logic       exp_q[$];

  joypad_port #(.DB_W(16), .DB_CYCLES(4), .FILL_BIT(1'b1)) dut (
    .CLK(CLK), .RES(RES), .BTN1(BTN1), .BTN2(BTN2), .STROBE(STROBE),
    .RD1(RD1), .RD2(RD2), .DOUT1(DOUT1), .DOUT2(DOUT2),
    .PRESSED1(PRESSED1), .PRESSED2(PRESSED2)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_strobe();
    STROBE = 1'b1;
    tk(1);
    STROBE = 1'b0;
    sr1_m  = exp_p1;
    sr2_m  = exp_p2;
  endtask

  // Push the model bit, score it against the DUT, then issue one read pulse.
  task automatic read_port(input int port, input string tag);
    logic e, got;
    exp_q.push_back(port == 1 ? sr1_m[0] : sr2_m[0]);
    got = (port == 1) ? DOUT1 : DOUT2;
    e   = exp_q.pop_front();
    check_val(tag, {7'd0, got}, {7'd0, e});
    if (port == 1) RD1 = 1'b1; else RD2 = 1'b1;
    tk(1);
    RD1 = 1'b0;
    RD2 = 1'b0;
    tk(1);
    if (port == 1) sr1_m = {1'b1, sr1_m[7:1]};
    else           sr2_m = {1'b1, sr2_m[7:1]};
  endtask

  initial begin
    RES = 1'b0; BTN1 = 8'hFF; BTN2 = 8'hFF; STROBE = 1'b1; RD1 = 1'b0; RD2 = 1'b0;
    exp_p1 = 8'h00; exp_p2 = 8'h00; sr1_m = 8'h00; sr2_m = 8'h00;

    // Reset with buttons held and strobe high
    tk(2);
    check_val("rst_dout1", {7'd0, DOUT1}, 8'h00);
    check_val("rst_dout2", {7'd0, DOUT2}, 8'h00);
    check_val("rst_p1", PRESSED1, 8'h00);
    check_val("rst_p2", PRESSED2, 8'h00);
    RES = 1'b1; BTN1 = 8'h00; BTN2 = 8'h00; STROBE = 1'b0;
    tk(4);

    // Debounce latency 2+4 cycles, then a 3-cycle glitch
    BTN1 = 8'h01;
    tk(5);
    check_val("db_early", PRESSED1, 8'h00);
    tk(1);
    check_val("db_accept", PRESSED1, 8'h01);
    BTN1 = 8'h03;
    tk(3);
    BTN1 = 8'h01;
    tk(10);
    check_val("db_glitch", PRESSED1, 8'h01);

    // Serial read of 8'b1001_0101 with two fill reads
    BTN1 = 8'h95; exp_p1 = 8'h95;
    tk(8);
    check_val("p1_95", PRESSED1, 8'h95);
    do_strobe();
    for (int i = 0; i < 10; i++) read_port(1, $sformatf("rd1_%0d", i));

    // Held read shifts once
    do_strobe();
    RD1 = 1'b1;
    tk(5);
    RD1 = 1'b0;
    tk(1);
    sr1_m = {1'b1, sr1_m[7:1]};
    read_port(1, "held_1");
    read_port(1, "held_2");

    // Reads while strobe is high never shift
    STROBE = 1'b1;
    tk(1);
    for (int i = 0; i < 3; i++) begin
      RD1 = 1'b1;
      tk(1);
      check_val($sformatf("strb_rd_%0d", i), {7'd0, DOUT1}, {7'd0, exp_p1[0]});
      RD1 = 1'b0;
      tk(1);
    end
    STROBE = 1'b0;
    sr1_m  = exp_p1;

    // Port independence
    BTN2 = 8'h80; exp_p2 = 8'h80;
    tk(8);
    check_val("p2_80", PRESSED2, 8'h80);
    do_strobe();
    read_port(1, "ind_p1_a");
    read_port(1, "ind_p1_b");
    for (int i = 0; i < 9; i++) read_port(2, $sformatf("rd2_%0d", i));
    check_val("p1_hold", {7'd0, DOUT1}, {7'd0, sr1_m[0]});
    read_port(1, "ind_p1_c");

    // Strobe rise together with an RD2 edge: load wins
    STROBE = 1'b1; RD2 = 1'b1;
    tk(1);
    sr2_m  = exp_p2;
    STROBE = 1'b0;
    check_val("collide", {7'd0, DOUT2}, {7'd0, sr2_m[0]});
    tk(1);
    check_val("collide_held", {7'd0, DOUT2}, {7'd0, sr2_m[0]});
    RD2 = 1'b0;
    tk(1);
    for (int i = 0; i < 8; i++) read_port(2, $sformatf("col_rd2_%0d", i));

    // Reset mid-shift, then restart from A
    do_strobe();
    for (int i = 0; i < 3; i++) read_port(1, $sformatf("pre_rst_%0d", i));
    RES = 1'b0;
    tk(1);
    RES = 1'b1;
    sr1_m = 8'h00; sr2_m = 8'h00;
    check_val("mid_rst_dout1", {7'd0, DOUT1}, 8'h00);
    check_val("mid_rst_p1", PRESSED1, 8'h00);
    tk(8);
    check_val("re_db_p1", PRESSED1, exp_p1);
    do_strobe();
    for (int i = 0; i < 8; i++) read_port(1, $sformatf("post_rst_%0d", i));

    if (exp_q.size() != 0) check_val("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
